// File: rtl/i2c_timer.sv
// i2c_timer
//
// Bit and ACK-slot sequencer for an I2C receiver. It follows the SCL edge and
// START/STOP pulses from the line detectors. It tells the receive shifter when
// to sample SDA, and it frames the ACK slot that follows every byte.
//
// Parameters
//   BITS               data bits per byte before the ACK slot (1..15)
//
// Ports
//   clk                system clock; all logic on the rising edge
//   n_rst              synchronous, active-low reset
//   rising_edge_found  one-cycle pulse per SCL rising edge
//   falling_edge_found one-cycle pulse per SCL falling edge
//   start_found        one-cycle pulse on START or repeated START
//   stop_found         one-cycle pulse on STOP
//   shift_strobe       registered pulse: sample SDA into the shifter
//   byte_received      registered pulse: the BITS-th data bit was just sampled
//   ack_prep           registered pulse: falling edge that opens the ACK slot
//   check_ack          registered pulse: rising edge inside the ACK slot
//   ack_done           registered pulse: falling edge that closes the ACK slot
//   busy               high whenever the sequencer is not idle
module i2c_timer #(
  parameter int BITS = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rising_edge_found,
  input  logic falling_edge_found,
  input  logic start_found,
  input  logic stop_found,
  output logic shift_strobe,
  output logic byte_received,
  output logic ack_prep,
  output logic check_ack,
  output logic ack_done,
  output logic busy
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WAIT_ACK,
    ACK_SLOT,
    ACK_HOLD
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;

  logic strobe_reg, strobe_next;
  logic byte_reg,   byte_next;
  logic prep_reg,   prep_next;
  logic check_reg,  check_next;
  logic done_reg,   done_next;

  // A rising and a falling edge reported together cannot both be real.
  // Neither one is trusted in that case.
  logic rise_ok;
  logic fall_ok;

  assign rise_ok = rising_edge_found  && !falling_edge_found;
  assign fall_ok = falling_edge_found && !rising_edge_found;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    strobe_next = 1'b0;
    byte_next   = 1'b0;
    prep_next   = 1'b0;
    check_next  = 1'b0;
    done_next   = 1'b0;

    // STOP beats START, and START beats any edge. Either one drops the
    // current byte silently.
    if (stop_found) begin
      state_next = IDLE;
      count_next = '0;
    end else if (start_found) begin
      state_next = DATA;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Edges outside a transfer mean nothing.
        end
        DATA: begin
          if (rise_ok) begin
            strobe_next = 1'b1;
            count_next  = count_reg + ONE;
            // The counter stops at BITS: the last bit moves the sequencer
            // out of DATA before another increment can happen.
            if (count_reg + ONE == LAST) begin
              byte_next  = 1'b1;
              state_next = WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (fall_ok) begin
            prep_next  = 1'b1;
            state_next = ACK_SLOT;
          end
        end
        ACK_SLOT: begin
          if (rise_ok) begin
            check_next = 1'b1;
            state_next = ACK_HOLD;
          end
        end
        ACK_HOLD: begin
          if (fall_ok) begin
            done_next  = 1'b1;
            count_next = '0;
            state_next = DATA;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      strobe_reg <= 1'b0;
      byte_reg   <= 1'b0;
      prep_reg   <= 1'b0;
      check_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      strobe_reg <= strobe_next;
      byte_reg   <= byte_next;
      prep_reg   <= prep_next;
      check_reg  <= check_next;
      done_reg   <= done_next;
    end
  end

  assign shift_strobe  = strobe_reg;
  assign byte_received = byte_reg;
  assign ack_prep      = prep_reg;
  assign check_ack     = check_reg;
  assign ack_done      = done_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: doc/i2c_timer.md
I2C_TIMER -- requirements
Module: i2c_timer

Interface
REQ-001 Parameter: BITS, default 8, data bits per byte before the ACK slot (legal 1..15).
REQ-002 Port: clk  in  1  system clock; all logic on rising edge.
REQ-003 Port: n_rst  in  1  reset, synchronous, active-low.
REQ-004 Port: rising_edge_found  in  1  one-cycle pulse per SCL rising edge from the SCL edge detector.
REQ-005 Port: falling_edge_found  in  1  one-cycle pulse per SCL falling edge from the SCL edge detector.
REQ-006 Port: start_found  in  1  one-cycle pulse on a START or repeated-START condition.
REQ-007 Port: stop_found  in  1  one-cycle pulse on a STOP condition.
REQ-008 Port: shift_strobe  out  1  one-cycle pulse telling the receive shifter to sample SDA.
REQ-009 Port: byte_received  out  1  one-cycle pulse after the BITS-th data bit.
REQ-010 Port: ack_prep  out  1  one-cycle pulse at the falling edge that opens the ACK slot.
REQ-011 Port: check_ack  out  1  one-cycle pulse at the rising edge inside the ACK slot.
REQ-012 Port: ack_done  out  1  one-cycle pulse at the falling edge that closes the ACK slot.
REQ-013 Port: busy  out  1  high while the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, DATA, WAIT_ACK, ACK_SLOT and ACK_HOLD, with a bit counter of ceil(log2(BITS+1)) bits.
REQ-015 In IDLE, start_found SHALL move the block to DATA and clear the bit counter; all edge inputs SHALL be ignored.
REQ-016 In DATA, rising_edge_found SHALL pulse shift_strobe and increment the bit counter; falling edges SHALL be ignored.
REQ-017 In DATA, the rising edge that brings the count to BITS SHALL also pulse byte_received and move the block to WAIT_ACK.
REQ-018 In WAIT_ACK, falling_edge_found SHALL pulse ack_prep and move the block to ACK_SLOT; rising edges SHALL be ignored.
REQ-019 In ACK_SLOT, rising_edge_found SHALL pulse check_ack and move the block to ACK_HOLD.
REQ-020 In ACK_HOLD, falling_edge_found SHALL pulse ack_done, clear the bit counter and return the block to DATA for the next byte.
REQ-021 All pulse outputs SHALL be registered: high for exactly one cycle, in the cycle after the triggering input is sampled (latency 1).
REQ-022 busy SHALL be decoded directly from the state register, with no added latency.
REQ-023 stop_found SHALL force IDLE from any state, clear the counter and suppress every pulse output in the following cycle.
REQ-024 start_found in any non-IDLE state (repeated START) SHALL force DATA and clear the counter, aborting any byte or ACK in progress with no pulses.
REQ-025 Priority SHALL be stop_found > start_found > edge inputs when they arrive in the same cycle.
REQ-026 rising_edge_found and falling_edge_found arriving in the same cycle SHALL be ignored: no state change, no pulses.
REQ-027 The bit counter SHALL never exceed BITS, and no wrap-around SHALL occur.
REQ-028 In DATA with BITS=1, the first rising edge SHALL give shift_strobe and byte_received in the same cycle.

Reset
REQ-029 While n_rst=0 at a clk edge, the block SHALL enter IDLE with counter=0 and shift_strobe, byte_received, ack_prep, check_ack, ack_done and busy all 0.
REQ-030 Reset mid-byte or mid-ACK SHALL abandon the transfer; in the cycle after n_rst returns high, no pulse SHALL be asserted.
REQ-031 Reset SHALL have no asynchronous effect: with n_rst=0 between clk edges, the outputs SHALL hold.

Verification
REQ-032 Full byte, BITS=8: start, then 8 rising/falling pairs, then 1 more pair -> 8 shift_strobe pulses; byte_received with the 8th strobe; ack_prep after the 8th falling edge; check_ack on the 9th rising edge; ack_done on the 9th falling edge; busy stays 1.
REQ-033 Back-to-back bytes: two complete 9-clock sequences after one start -> 16 shift_strobe, 2 byte_received, 2 ack_done; counter at 0 after the second ack_done.
REQ-034 Stop mid-byte: stop_found after 3 rising edges -> busy=0 on the next cycle; later edges give no pulses until a new start_found.
REQ-035 Repeated start: start_found in ACK_SLOT -> no check_ack; next 8 rising edges give 8 strobes and 1 byte_received.
REQ-036 Collisions: stop_found with start_found -> IDLE; rising with falling in DATA -> counter unchanged, no strobe.
REQ-037 Reset mid-transfer: n_rst=0 for 1 cycle after 5 strobes, then start -> 8 more rising edges needed for byte_received; all outputs 0 during reset.
